// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller decoder.
// Latency: none (declarations and a combinational lookup function only).
// Backpressure: none; the PS/2 link cannot be stalled.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Controller bit positions, shared by c1 and c2.
  localparam logic [3:0] BTN_UP      = 4'd0;
  localparam logic [3:0] BTN_DOWN    = 4'd1;
  localparam logic [3:0] BTN_LEFT    = 4'd2;
  localparam logic [3:0] BTN_RIGHT   = 4'd3;
  localparam logic [3:0] BTN_PUNCH   = 4'd4;
  localparam logic [3:0] BTN_KICK    = 4'd5;
  localparam logic [3:0] BTN_BLOCK   = 4'd6;
  localparam logic [3:0] BTN_JUMP    = 4'd7;
  localparam logic [3:0] BTN_SPECIAL = 4'd8;
  localparam logic [3:0] BTN_START   = 4'd9;

  // Key codes are {ext, scancode}: bit 8 set means the E0 prefix preceded it.
  localparam logic [8:0] KEY_P1_UP      = 9'h01D;  // W
  localparam logic [8:0] KEY_P1_DOWN    = 9'h01B;  // S
  localparam logic [8:0] KEY_P1_LEFT    = 9'h01C;  // A
  localparam logic [8:0] KEY_P1_RIGHT   = 9'h023;  // D
  localparam logic [8:0] KEY_P1_PUNCH   = 9'h02B;  // F
  localparam logic [8:0] KEY_P1_KICK    = 9'h034;  // G
  localparam logic [8:0] KEY_P1_BLOCK   = 9'h033;  // H
  localparam logic [8:0] KEY_P1_JUMP    = 9'h029;  // space
  localparam logic [8:0] KEY_P1_SPECIAL = 9'h02D;  // R
  localparam logic [8:0] KEY_P1_START   = 9'h05A;  // enter
  localparam logic [8:0] KEY_P2_UP      = 9'h175;  // arrow up
  localparam logic [8:0] KEY_P2_DOWN    = 9'h172;  // arrow down
  localparam logic [8:0] KEY_P2_LEFT    = 9'h16B;  // arrow left
  localparam logic [8:0] KEY_P2_RIGHT   = 9'h174;  // arrow right
  localparam logic [8:0] KEY_P2_PUNCH   = 9'h069;  // keypad 1
  localparam logic [8:0] KEY_P2_KICK    = 9'h072;  // keypad 2
  localparam logic [8:0] KEY_P2_BLOCK   = 9'h07A;  // keypad 3
  localparam logic [8:0] KEY_P2_JUMP    = 9'h070;  // keypad 0
  localparam logic [8:0] KEY_P2_SPECIAL = 9'h071;  // keypad .
  localparam logic [8:0] KEY_P2_START   = 9'h15A;  // keypad enter

  typedef struct packed {
    logic       hit;
    logic       p2;
    logic [3:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_lookup(input logic [8:0] code);
    key_hit_t r;
    r = '0;
    case (code)
      KEY_P1_UP:      r = '{1'b1, 1'b0, BTN_UP};
      KEY_P1_DOWN:    r = '{1'b1, 1'b0, BTN_DOWN};
      KEY_P1_LEFT:    r = '{1'b1, 1'b0, BTN_LEFT};
      KEY_P1_RIGHT:   r = '{1'b1, 1'b0, BTN_RIGHT};
      KEY_P1_PUNCH:   r = '{1'b1, 1'b0, BTN_PUNCH};
      KEY_P1_KICK:    r = '{1'b1, 1'b0, BTN_KICK};
      KEY_P1_BLOCK:   r = '{1'b1, 1'b0, BTN_BLOCK};
      KEY_P1_JUMP:    r = '{1'b1, 1'b0, BTN_JUMP};
      KEY_P1_SPECIAL: r = '{1'b1, 1'b0, BTN_SPECIAL};
      KEY_P1_START:   r = '{1'b1, 1'b0, BTN_START};
      KEY_P2_UP:      r = '{1'b1, 1'b1, BTN_UP};
      KEY_P2_DOWN:    r = '{1'b1, 1'b1, BTN_DOWN};
      KEY_P2_LEFT:    r = '{1'b1, 1'b1, BTN_LEFT};
      KEY_P2_RIGHT:   r = '{1'b1, 1'b1, BTN_RIGHT};
      KEY_P2_PUNCH:   r = '{1'b1, 1'b1, BTN_PUNCH};
      KEY_P2_KICK:    r = '{1'b1, 1'b1, BTN_KICK};
      KEY_P2_BLOCK:   r = '{1'b1, 1'b1, BTN_BLOCK};
      KEY_P2_JUMP:    r = '{1'b1, 1'b1, BTN_JUMP};
      KEY_P2_SPECIAL: r = '{1'b1, 1'b1, BTN_SPECIAL};
      KEY_P2_START:   r = '{1'b1, 1'b1, BTN_START};
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: sync, clock glitch filter, 11-bit frame FSM, watchdog.
// Latency: fall 2+FILTER_LEN cycles after pin edge; byte_valid/frame_err 1 cycle after stop fall.
// Backpressure: none; bytes are single-cycle pulses. PS2_PARITY_CHECK_EN enables odd parity check.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 108000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, fall;
  logic [FW-1:0] flt_cnt;
  frame_state_t  state, state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [WW-1:0] wd_cnt;
  logic          accept, err, timeout, par_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_bit;
`endif

  // Two-flop synchronizers; lines idle high so reset to 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        flt_cnt  <= '0;
        fall     <= clk_filt & ~clk_s2;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  // wd_cnt is the number of cycles since the last fall strobe, so the error
  // pulse lands exactly TIMEOUT_CYCLES after it. A coinciding fall wins.
  assign timeout = (state != ST_IDLE) && !fall && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  // Frame FSM next state and accept/error decisions.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    err     = 1'b0;
    if (timeout) begin
      state_n = ST_IDLE;
      err     = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (dat_s2) err = 1'b1;
          else        state_n = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: state_n = ST_STOP;
        ST_STOP: begin
          if (dat_s2 && par_ok) accept = 1'b1;
          else                  err    = 1'b1;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Shift register, bit counter, watchdog and output pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      wd_cnt     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      byte_valid <= accept;
      frame_err  <= err;
      if (accept) byte_out <= shreg;

      if (timeout) begin
        shreg <= '0;
      end else if (fall) begin
        case (state)
          ST_IDLE: bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef PS2_PARITY_CHECK_EN
          ST_PARITY: par_bit <= dat_s2;
`endif
          default: ;
        endcase
      end

      if (fall)                             wd_cnt <= WW'(1);
      else if (state != ST_IDLE && !timeout) wd_cnt <= wd_cnt + WW'(1);
      else                                  wd_cnt <= '0;
    end
  end

endmodule

// File: rtl/ps2_controller_decoder.sv
// PS/2 keyboard to two 10-bit held-button vectors (c1 player 1, c2 player 2).
// Latency: byte_valid 1 cycle, c1/c2 2 cycles after the stop-bit fall strobe.
// Backpressure: none; every accepted byte is decoded immediately. PS2_PARITY_CHECK_EN passes to the receiver.
module ps2_controller_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 108000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [9:0] c1,
  output logic [9:0] c2,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  logic     ext, brk;
  key_hit_t key;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign key = key_lookup({ext, byte_out});

  // Prefix tracking and level-held button updates; repeats of a make are idempotent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext <= 1'b0;
      brk <= 1'b0;
      c1  <= '0;
      c2  <= '0;
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      if (byte_out == SC_EXT) begin
        ext <= 1'b1;
      end else if (byte_out == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (key.hit) begin
          if (key.p2) c2[key.idx] <= ~brk;
          else        c1[key.idx] <= ~brk;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_controller_decoder.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and checks them.
// Latency checked: c1/c2 one cycle after each byte_valid/frame_err, timeout error cycle exact.
// Backpressure: none on the DUT; pins driven with slow PS/2-like timing.
module tb_ps2_controller_decoder;

  localparam int FL = 8;
  localparam int TO = 300;

  logic       clock, reset, ps2_clk, ps2_dat;
  logic [9:0] c1, c2;
  logic [7:0] byte_out;
  logic       byte_valid, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fall_cyc = 0;

  typedef struct {
    bit         err;
    logic [7:0] dat;
    int         cyc;
    logic [9:0] c1;
    logic [9:0] c2;
  } exp_t;

  exp_t sb[$];

  ps2_controller_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .c1         (c1),
    .c2         (c2),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input bit err, input logic [7:0] d, input int ec,
                           input logic [9:0] e1, input logic [9:0] e2);
    exp_t e;
    e.err = err; e.dat = d; e.cyc = ec; e.c1 = e1; e.c2 = e2;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input bit b, input bit glitch);
    wait_cyc(1);
    ps2_dat = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(15);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(15);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop, input int glitch_at);
    logic [10:0] f;
    f = {stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(f[i], i == glitch_at);
    ps2_dat = 1'b1;
    wait_cyc(20);
  endtask

  task automatic key(input logic [7:0] d, input logic [9:0] e1, input logic [9:0] e2);
    expect_ev(1'b0, d, -1, e1, e2);
    send_frame(d, 1'b0, 1'b1, -1);
  endtask

  // Monitor: pop one expectation per output event, check c1/c2 on the next cycle.
  initial begin : monitor
    bit         pend;
    logic [9:0] pc1, pc2;
    exp_t       e;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (pend) begin
        check("c1", {22'd0, c1}, {22'd0, pc1});
        check("c2", {22'd0, c2}, {22'd0, pc2});
        pend = 1'b0;
      end
      if (!reset && (byte_valid || frame_err)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: byte_valid=%0b frame_err=%0b byte_out=%0h, expected none",
                   byte_valid, frame_err, byte_out);
        end else begin
          e = sb.pop_front();
          check("frame_err_kind", {31'd0, frame_err}, {31'd0, e.err});
          if (!e.err) check("byte_out", {24'd0, byte_out}, {24'd0, e.dat});
          if (e.cyc >= 0) check("timeout_cycle", cyc, e.cyc);
          pc1 = e.c1; pc2 = e.c2; pend = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    logic [10:0] f;
    logic [9:0]  par_c1;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    wait_cyc(5);
    check("rst_c1", {22'd0, c1}, 32'd0);
    check("rst_c2", {22'd0, c2}, 32'd0);
    check("rst_byte_out", {24'd0, byte_out}, 32'd0);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    wait_cyc(20);

    // Player 1 make/break, auto-repeat
    key(8'h1D, 10'h001, 10'h000);
    key(8'h1D, 10'h001, 10'h000);
    key(8'hF0, 10'h001, 10'h000);
    key(8'h1D, 10'h000, 10'h000);

    // Player 2 extended keys while P1 punch is held
    key(8'h2B, 10'h010, 10'h000);
    key(8'hE0, 10'h010, 10'h000);
    key(8'h6B, 10'h010, 10'h004);
    key(8'h69, 10'h010, 10'h014);
    key(8'hE0, 10'h010, 10'h014);
    key(8'hF0, 10'h010, 10'h014);
    key(8'h6B, 10'h010, 10'h010);
    key(8'hF0, 10'h010, 10'h010);
    key(8'h69, 10'h010, 10'h000);
    key(8'hF0, 10'h010, 10'h000);
    key(8'h2B, 10'h000, 10'h000);

    // Wrong parity
`ifdef PS2_PARITY_CHECK_EN
    par_c1 = 10'h000;
    expect_ev(1'b1, 8'h00, -1, par_c1, 10'h000);
`else
    par_c1 = 10'h001;
    expect_ev(1'b0, 8'h1D, -1, par_c1, 10'h000);
`endif
    send_frame(8'h1D, 1'b1, 1'b1, -1);
    key(8'hF0, par_c1, 10'h000);
    key(8'h1D, 10'h000, 10'h000);

    // Start bit of 1
    expect_ev(1'b1, 8'h00, -1, 10'h000, 10'h000);
    drive_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(20);

    // Bad stop bit clears a pending E0: plain 72 is P2 kick, not P2 down
    key(8'hE0, 10'h000, 10'h000);
    expect_ev(1'b1, 8'h00, -1, 10'h000, 10'h000);
    send_frame(8'h72, 1'b0, 1'b0, -1);
    key(8'h72, 10'h000, 10'h020);
    key(8'hF0, 10'h000, 10'h020);
    key(8'h72, 10'h000, 10'h000);

    // Timeout after start + 4 data bits
    f = {1'b1, 1'b1, 8'h1D, 1'b0};
    for (int i = 0; i < 5; i++) drive_bit(f[i], 1'b0);
    expect_ev(1'b1, 8'h00, last_fall_cyc + 2 + FL + TO, 10'h000, 10'h000);
    ps2_dat = 1'b1;
    wait_cyc(TO + 50);
    key(8'h23, 10'h008, 10'h000);
    key(8'hF0, 10'h008, 10'h000);
    key(8'h23, 10'h000, 10'h000);

    // 3-cycle clock glitch mid-frame
    expect_ev(1'b0, 8'h1B, -1, 10'h002, 10'h000);
    send_frame(8'h1B, 1'b0, 1'b1, 4);
    key(8'hF0, 10'h002, 10'h000);
    key(8'h1B, 10'h000, 10'h000);

    // Reset mid-frame while W and D are held
    key(8'h1D, 10'h001, 10'h000);
    key(8'h23, 10'h009, 10'h000);
    f = {1'b1, ~^8'h1B, 8'h1B, 1'b0};
    for (int i = 0; i < 4; i++) drive_bit(f[i], 1'b0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midrst_c1", {22'd0, c1}, 32'd0);
    check("midrst_c2", {22'd0, c2}, 32'd0);
    check("midrst_byte_out", {24'd0, byte_out}, 32'd0);
    check("midrst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(30);
    key(8'h1B, 10'h002, 10'h000);

    wait_cyc(50);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
